// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: buffers ALU and LSB results in small per-source FIFOs
// and broadcasts at most one per cycle, picking between the two round-robin.
module cdb_arbiter #(
    parameter int ROB_ID_W = 4,
    parameter int QDEPTH   = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                rdy,
    input  logic                rob_clear,
    input  logic                alu_valid,
    input  logic [ROB_ID_W-1:0] alu_rob_id,
    input  logic [31:0]         alu_value,
    output logic                alu_stall,
    input  logic                lsb_valid,
    input  logic [ROB_ID_W-1:0] lsb_rob_id,
    input  logic [31:0]         lsb_value,
    output logic                lsb_stall,
    output logic                cdb_valid,
    output logic [ROB_ID_W-1:0] cdb_rob_id,
    output logic [31:0]         cdb_value,
    output logic                cdb_src,
    output logic                overflow
);

    localparam int PTR_W = $clog2(QDEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic SRC_LSB = 1'b1;

    // Index 0 is the ALU side, index 1 the LSB side, matching cdb_src encoding.
    logic [ROB_ID_W-1:0] mem_id  [2][QDEPTH];
    logic [31:0]         mem_val [2][QDEPTH];
    logic [PTR_W-1:0]    head [2];
    logic [PTR_W-1:0]    tail [2];
    logic [CNT_W-1:0]    cnt  [2];
    logic                rr_last;

    logic [1:0]          in_valid;
    logic [ROB_ID_W-1:0] in_id  [2];
    logic [31:0]         in_val [2];
    logic [1:0]          stall;
    logic [1:0]          elig;
    logic [1:0]          push;
    logic [1:0]          pop;
    logic                any_grant;
    logic                win;
    logic [ROB_ID_W-1:0] win_id;
    logic [31:0]         win_val;

    assign in_valid  = {lsb_valid, alu_valid};
    assign in_id[0]  = alu_rob_id;
    assign in_id[1]  = lsb_rob_id;
    assign in_val[0] = alu_value;
    assign in_val[1] = lsb_value;
    assign alu_stall = stall[0];
    assign lsb_stall = stall[1];

    // An empty FIFO lets a fresh input bypass straight to the bus.
    always_comb begin
        stall     = '0;
        elig      = '0;
        push      = '0;
        pop       = '0;
        for (int s = 0; s < 2; s++) begin
            stall[s] = (cnt[s] == CNT_W'(QDEPTH));
            elig[s]  = (cnt[s] != '0) || in_valid[s];
        end
        any_grant = |elig;
        win       = (elig[0] && elig[1]) ? ~rr_last : elig[1];
        win_id    = (cnt[win] != '0) ? mem_id[win][head[win]]  : in_id[win];
        win_val   = (cnt[win] != '0) ? mem_val[win][head[win]] : in_val[win];
        for (int s = 0; s < 2; s++) begin
            pop[s]  = any_grant && (win == 1'(s)) && (cnt[s] != '0);
            push[s] = in_valid[s] && !stall[s] &&
                      ((cnt[s] != '0) || !(any_grant && (win == 1'(s))));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int s = 0; s < 2; s++) begin
                head[s] <= '0;
                tail[s] <= '0;
                cnt[s]  <= '0;
            end
            rr_last    <= SRC_LSB;
            cdb_valid  <= 1'b0;
            cdb_rob_id <= '0;
            cdb_value  <= '0;
            cdb_src    <= 1'b0;
            overflow   <= 1'b0;
        end else if (rdy) begin
            if (rob_clear) begin
                for (int s = 0; s < 2; s++) begin
                    head[s] <= '0;
                    tail[s] <= '0;
                    cnt[s]  <= '0;
                end
                rr_last   <= SRC_LSB;
                cdb_valid <= 1'b0;
            end else begin
                for (int s = 0; s < 2; s++) begin
                    if (push[s])
                        tail[s] <= tail[s] + PTR_W'(1);
                    if (pop[s])
                        head[s] <= head[s] + PTR_W'(1);
                    if (push[s] && !pop[s])
                        cnt[s] <= cnt[s] + CNT_W'(1);
                    else if (pop[s] && !push[s])
                        cnt[s] <= cnt[s] - CNT_W'(1);
                    if (in_valid[s] && stall[s])
                        overflow <= 1'b1;
                end
                cdb_valid <= any_grant;
                if (any_grant) begin
                    cdb_rob_id <= win_id;
                    cdb_value  <= win_val;
                    cdb_src    <= win;
                    rr_last    <= win;
                end
            end
        end
    end

    // Storage needs no reset: entries are only read once counted as occupied.
    always_ff @(posedge clk) begin
        if (rdy && !rob_clear) begin
            for (int s = 0; s < 2; s++) begin
                if (push[s]) begin
                    mem_id[s][tail[s]]  <= in_id[s];
                    mem_val[s][tail[s]] <= in_val[s];
                end
            end
        end
    end

endmodule
